// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks (TX controller now, RX later).
package uart_pkg;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_CLKS_PER_BIT_DEFAULT = 868;   // 100 MHz / 115200 baud

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of every period. Clearing on !enable keeps each new frame phase-aligned.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic enable,
   output logic tick_o
);

   localparam int                CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] baud_cnt;

   // Period counter: held at zero while disabled, wraps at the period end.
   // NOTE: flops are written with <= so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         baud_cnt <= '0;
      end else if (!enable) begin
         baud_cnt <= '0;
      end else if (baud_cnt == LAST) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

   assign tick_o = enable && (baud_cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller. Sequences the external 9-bit TX shift
// register (load, shift, clear) and muxes its serial output with idle, stop
// and parity levels onto a registered TX line.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after DATA.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       tx_valid_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_ready_o,
   output logic [7:0] sr_data_o,
   output logic       sr_load_o,
   output logic       sr_shift_o,
   output logic       sr_clear_o,
   input  logic       sr_serial_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       tx_done_o
);

   localparam int              BIT_CNT_W = $clog2(UART_DATA_BITS);
   localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(UART_DATA_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

   uart_tx_state_e         state;
   uart_tx_state_e         state_next;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic                   clearing;
   logic                   tick;
   logic                   baud_en;
   logic                   line;
   logic                   accept;

   // Baud timing only runs once the frame is on the line.
   assign baud_en = (state != IDLE) && (state != LOAD);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .enable   (baud_en),
      .tick_o   (tick)
   );

   assign accept = tx_valid_i && tx_ready_o;

   // State register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: frame sequencing, advanced by baud ticks.
   // NOTE: state_next gets a default first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:   if (accept) state_next = LOAD;
         LOAD:   state_next = START;
         START:  if (tick) state_next = DATA;
         DATA: begin
            if (tick && (bit_cnt == LAST_DATA)) begin
`ifdef UART_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
         PARITY: if (tick) state_next = STOP;
         STOP:   if (tick && (bit_cnt == LAST_STOP)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: handshake, shift-register strobes and line source select.
   always_comb begin
      tx_ready_o = (state == IDLE) && !clearing;
      busy_o     = (state != IDLE);
      sr_load_o  = (state == LOAD);
      sr_shift_o = tick && ((state == START) || (state == DATA));
      tx_done_o  = tick && (state == STOP) && (bit_cnt == LAST_STOP);
      line       = 1'b1;
      unique case (state)
         START, DATA: line = sr_serial_i;
         PARITY:      line = (^sr_data_o) ^ (PARITY_ODD != 0);
         default:     line = 1'b1;
      endcase
   end

   // Bit / stop-period counter: restarts at 0 whenever a phase completes.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         bit_cnt <= '0;
      end else if (tick) begin
         unique case (state)
            DATA:    bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
            STOP:    bit_cnt <= (bit_cnt == LAST_STOP) ? '0 : bit_cnt + 1'b1;
            default: bit_cnt <= '0;
         endcase
      end
   end

   // Byte capture, registered TX line and post-reset clear of the shift register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         sr_data_o <= '0;
         tx_o      <= 1'b1;
         clearing  <= 1'b1;
      end else begin
         if (accept) sr_data_o <= tx_data_i;
         tx_o     <= line;
         clearing <= 1'b0;
      end
   end

   assign sr_clear_o = clearing;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with a behavioural 9-bit TX shift register behind it.
// Expected frames are queued when a byte is handed over and compared, sample
// by sample, when the line monitor sees the corresponding start bit.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

   localparam int CPB  = 4;
   localparam int NVEC = 6;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_SAMPLES = FRAME_BITS * CPB;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;    // line bits in time order, bit 0 first: start, d0..d7, stop
      logic       parity;   // even parity of data
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic [7:0] sr_data;
   logic       sr_load;
   logic       sr_shift;
   logic       sr_clear;
   logic       sr_serial;
   logic       tx_o;
   logic       busy;
   logic       tx_done;

   logic [8:0] sr;
   vec_t       vecs [NVEC];
   vec_t       sb [$];
   int         n_checks = 0;
   int         n_pass = 0;
   int         frames_seen = 0;
   int         last_gap = -1;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_ctrl #(
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (1),
      .PARITY_ODD   (0)
   ) dut (
      .clk_i       (clk),
      .reset_ni    (rst_n),
      .tx_valid_i  (tx_valid),
      .tx_data_i   (tx_data),
      .tx_ready_o  (tx_ready),
      .sr_data_o   (sr_data),
      .sr_load_o   (sr_load),
      .sr_shift_o  (sr_shift),
      .sr_clear_o  (sr_clear),
      .sr_serial_i (sr_serial),
      .tx_o        (tx_o),
      .busy_o      (busy),
      .tx_done_o   (tx_done)
   );

   // 9-bit TX shift register: bit 0 is the serial output and the start bit.
   always_ff @(posedge clk) begin
      if (sr_clear)      sr <= '0;
      else if (sr_load)  sr <= {sr_data, sr[0]};
      else if (sr_shift) sr <= {1'b0, sr[8:1]};
   end
   assign sr_serial = sr[0];

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
   endtask

   function automatic logic [63:0] expected_samples(input vec_t r);
      logic [10:0] bits;
      logic [63:0] s;
`ifdef UART_TX_PARITY_EN
      bits = {1'b1, r.parity, r.frame[8:0]};
`else
      bits = {1'b0, r.frame};
`endif
      s = '0;
      for (int i = 0; i < FRAME_SAMPLES; i++) s[i] = bits[i / CPB];
      return s;
   endfunction

   // Offer a byte at a falling edge; queue its frame once the handshake is seen.
   task automatic send(input vec_t r, input bit keep_valid);
      int k;
      k = 0;
      tx_valid = 1'b1;
      tx_data  = r.data;
      while (!tx_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("ready_wait", tx_ready, 1'b1);
      if (tx_ready) sb.push_back(r);
      @(posedge clk);
      @(negedge clk);
      if (!keep_valid) begin
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
      end
   endtask

   task automatic wait_frames(input int n);
      int k;
      k = 0;
      while (frames_seen < n && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("frame_wait", frames_seen >= n, 1'b1);
   endtask

   // Line monitor: captures whole frames from the start bit and scores them.
   initial begin : line_monitor
      logic [63:0] samp;
      int          n;
      int          ones;
      bit          aborted;
      vec_t        exp_rec;
      ones = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ones = 0;
         end else if (tx_o === 1'b0) begin
            last_gap = ones;
            ones     = 0;
            samp     = '0;
            n        = 1;
            aborted  = 1'b0;
            while (n < FRAME_SAMPLES && !aborted) begin
               @(negedge clk);
               if (!rst_n) aborted = 1'b1;
               else begin
                  samp[n] = tx_o;
                  n++;
               end
            end
            if (aborted) begin
               if (sb.size() > 0) void'(sb.pop_front());
            end else begin
               check("frame_expected", sb.size() > 0, 1'b1);
               if (sb.size() > 0) begin
                  exp_rec = sb.pop_front();
                  check($sformatf("frame_%02h", exp_rec.data), samp, expected_samples(exp_rec));
               end
               frames_seen++;
            end
         end else begin
            ones++;
         end
      end
   end

   // Strobe monitor: frame length from load to done, shift count, load/shift exclusivity.
   initial begin : strobe_monitor
      int load_cyc;
      int shifts;
      bit overlap;
      load_cyc = 0;
      shifts   = 0;
      overlap  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            shifts  = 0;
            overlap = 1'b0;
         end else begin
            if (sr_load && sr_shift) overlap = 1'b1;
            if (sr_load) begin
               load_cyc = cyc;
               shifts   = 0;
            end
            if (sr_shift) shifts++;
            if (tx_done) begin
               check("done_latency", cyc - load_cyc, FRAME_SAMPLES);
               check("shift_count", shifts, 9);
               check("load_shift_excl", overlap, 1'b0);
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int target;
      int bad;
      vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
      vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
      vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
      vecs[3] = '{8'h3C, 10'b1_00111100_0, 1'b0};
      vecs[4] = '{8'h07, 10'b1_00000111_0, 1'b1};
      vecs[5] = '{8'h55, 10'b1_01010101_0, 1'b0};
      target   = 0;
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      // Reset and clear.
      repeat (3) @(negedge clk);
      check("rst_tx", tx_o, 1'b1);
      check("rst_clear", sr_clear, 1'b1);
      check("rst_ready", tx_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_strobes", {sr_load, sr_shift, tx_done}, 3'b000);
      check("rst_data", sr_data, 8'h00);
      #2 rst_n = 1'b1;
      #1;
      check("clear_hold", sr_clear, 1'b1);
      check("ready_in_clear", tx_ready, 1'b0);
      @(negedge clk);
      check("clear_release", sr_clear, 1'b0);
      check("ready_after_clear", tx_ready, 1'b1);

      // Table-driven single frames.
      for (int i = 0; i < NVEC; i++) begin
         send(vecs[i], 1'b0);
         target++;
         wait_frames(target);
         repeat (3) @(negedge clk);
      end

      // Back-to-back 0x00 then 0xFF with valid held high.
      send(vecs[1], 1'b1);
      send(vecs[2], 1'b0);
      target += 2;
      wait_frames(target);
      check("b2b_gap", last_gap, 2);

      // Backpressure: a byte offered during DATA waits for IDLE.
      send(vecs[0], 1'b0);
      target++;
      repeat (10) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = vecs[5].data;
      bad = 0;
      repeat (16) begin
         @(negedge clk);
         if (tx_ready !== 1'b0 || sr_data !== vecs[0].data) bad++;
      end
      check("bp_hold", bad, 0);
      send(vecs[5], 1'b0);
      target++;
      check("bp_capture", sr_data, vecs[5].data);
      wait_frames(target);

      // Reset during data bit 3 of 0xA5 (a 0 bit), then send 0x3C.
      repeat (3) @(negedge clk);
      send(vecs[0], 1'b0);
      repeat (18) @(negedge clk);
      check("pre_abort_line", tx_o, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("abort_tx", tx_o, 1'b1);
      check("abort_clear", sr_clear, 1'b1);
      check("abort_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("reclear_release", sr_clear, 1'b0);
      check("reclear_ready", tx_ready, 1'b1);
      send(vecs[3], 1'b0);
      target++;
      wait_frames(target);

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
